// File: rtl/bp_dyn_pkg.sv
// Shared types and counter-initialisation helpers for the lc3b dynamic branch predictor.
package bp_dyn_pkg;

   typedef logic [15:0] lc3b_word;

   // Per-cycle performance-counter increment events.
   typedef struct packed {
      logic hit_evt;
      logic mispredict_evt;
   } bp_stat_t;

   // Weakly-not-taken: MSB clear, lower bits set (0 for a 1-bit counter).
   function automatic logic [3:0] ctr_init_weak_nt(input int w);
      return 4'((1 << (w - 1)) - 1);
   endfunction

   // Weakly-taken: MSB set, lower bits clear.
   function automatic logic [3:0] ctr_init_weak_t(input int w);
      return 4'(1 << (w - 1));
   endfunction

endpackage

// File: rtl/bp_dyn_sat_ctr.sv
// Saturating up/down counter next-value logic; inc wins if both are raised.
module bp_sat_ctr #(
   parameter int W = 2
) (
   input  logic [W-1:0] cur_i,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] next_o
);

   always_comb begin
      next_o = cur_i;
      if (inc_i && (cur_i != {W{1'b1}})) begin
         next_o = cur_i + W'(1);
      end else if (!inc_i && dec_i && (cur_i != {W{1'b0}})) begin
         next_o = cur_i - W'(1);
      end
   end

endmodule

// File: rtl/bp_dyn.sv
// Direct-mapped dynamic branch predictor: same-cycle lookup, training from the
// resolving stage, mispredict/redirect generation and saturating stat counters.
module bp_dyn
   import bp_dyn_pkg::*;
#(
   parameter int INDEX_BITS = 4,
   parameter int CTR_BITS   = 2,
   parameter int STAT_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  lc3b_word             if_pc,
   input  logic                 if_is_branch,
   output logic                 pred_taken,
   output lc3b_word             pred_target,
   input  logic                 res_valid,
   input  lc3b_word             res_pc,
   input  logic                 res_taken,
   input  lc3b_word             res_target,
   input  logic                 res_pred_taken,
   input  lc3b_word             res_pred_target,
   output logic                 mispredict,
   output lc3b_word             redirect_pc,
   output logic [STAT_BITS-1:0] stat_hits,
   output logic [STAT_BITS-1:0] stat_mispredicts
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = 15 - INDEX_BITS;
   localparam logic [3:0] CTR_WNT_ALL = ctr_init_weak_nt(CTR_BITS);
   localparam logic [3:0] CTR_WT_ALL  = ctr_init_weak_t(CTR_BITS);
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WNT_ALL[CTR_BITS-1:0];
   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_WT_ALL[CTR_BITS-1:0];

   typedef struct packed {
      logic                valid;
      logic [TAG_W-1:0]    tag;
      lc3b_word            target;
      logic [CTR_BITS-1:0] ctr;
   } entry_t;

   localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

   entry_t                 table_q [ENTRIES];
   entry_t                 entry_d;
   logic                   write_en;
   logic [STAT_BITS-1:0]   stat_hits_q, stat_hits_d;
   logic [STAT_BITS-1:0]   stat_mis_q, stat_mis_d;
   bp_stat_t               stat_evt;

   logic [INDEX_BITS-1:0]  if_idx, res_idx;
   logic [TAG_W-1:0]       if_tag, res_tag;
   entry_t                 if_entry, res_entry;
   logic                   if_hit, res_hit;
   logic [CTR_BITS-1:0]    ctr_next;
   logic                   unused_pc_lsb;

   assign unused_pc_lsb = ^{if_pc[0], res_pc[0]};

   // Lookup: reads pre-update table state, so there is no same-cycle bypass.
   assign if_idx      = if_pc[INDEX_BITS:1];
   assign if_tag      = if_pc[15:INDEX_BITS+1];
   assign if_entry    = table_q[if_idx];
   assign if_hit      = if_is_branch & if_entry.valid & (if_entry.tag == if_tag);
   assign pred_taken  = rst_n & if_hit & if_entry.ctr[CTR_BITS-1];
   assign pred_target = pred_taken ? if_entry.target : 16'h0000;

   assign mispredict  = res_valid & ((res_taken != res_pred_taken) |
                        (res_taken & res_pred_taken & (res_target != res_pred_target)));
   assign redirect_pc = res_taken ? res_target : res_pc + 16'd2;

   assign res_idx   = res_pc[INDEX_BITS:1];
   assign res_tag   = res_pc[15:INDEX_BITS+1];
   assign res_entry = table_q[res_idx];
   assign res_hit   = res_entry.valid & (res_entry.tag == res_tag);

   bp_sat_ctr #(.W(CTR_BITS)) u_sat_ctr (
      .cur_i  (res_entry.ctr),
      .inc_i  (res_taken),
      .dec_i  (~res_taken),
      .next_o (ctr_next)
   );

   always_comb begin
      entry_d  = res_entry;
      write_en = 1'b0;
      if (res_valid) begin
         if (res_hit) begin
            write_en       = 1'b1;
            entry_d.ctr    = ctr_next;
            entry_d.target = res_taken ? res_target : res_entry.target;
         end else if (res_taken) begin
            write_en = 1'b1;
            entry_d  = '{valid: 1'b1, tag: res_tag, target: res_target, ctr: CTR_WT};
         end
      end
   end

   assign stat_evt.hit_evt        = pred_taken;
   assign stat_evt.mispredict_evt = mispredict;

   always_comb begin
      stat_hits_d = stat_hits_q;
      stat_mis_d  = stat_mis_q;
      if (stat_evt.hit_evt && (stat_hits_q != {STAT_BITS{1'b1}})) begin
         stat_hits_d = stat_hits_q + STAT_BITS'(1);
      end
      if (stat_evt.mispredict_evt && (stat_mis_q != {STAT_BITS{1'b1}})) begin
         stat_mis_d = stat_mis_q + STAT_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= ENTRY_RST;
         end
         stat_hits_q <= '0;
         stat_mis_q  <= '0;
      end else begin
         if (write_en) begin
            table_q[res_idx] <= entry_d;
         end
         stat_hits_q <= stat_hits_d;
         stat_mis_q  <= stat_mis_d;
      end
   end

   assign stat_hits        = stat_hits_q;
   assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_bp_dyn.sv
// Directed table-driven bench for bp_dyn with default parameters (4 index bits, 2-bit counters).
module tb_bp_dyn;

   logic        clk;
   logic        rst_n;
   logic [15:0] if_pc;
   logic        if_is_branch;
   logic        pred_taken;
   logic [15:0] pred_target;
   logic        res_valid;
   logic [15:0] res_pc;
   logic        res_taken;
   logic [15:0] res_target;
   logic        res_pred_taken;
   logic [15:0] res_pred_target;
   logic        mispredict;
   logic [15:0] redirect_pc;
   logic [15:0] stat_hits;
   logic [15:0] stat_mispredicts;

   int tests_run;
   int tests_failed;

   bp_dyn #(.INDEX_BITS(4), .CTR_BITS(2), .STAT_BITS(16)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .if_is_branch     (if_is_branch),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .res_valid        (res_valid),
      .res_pc           (res_pc),
      .res_taken        (res_taken),
      .res_target       (res_target),
      .res_pred_taken   (res_pred_taken),
      .res_pred_target  (res_pred_target),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .stat_hits        (stat_hits),
      .stat_mispredicts (stat_mispredicts)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] if_pc;
      logic        if_br;
      logic        rv;
      logic [15:0] rpc;
      logic        rt;
      logic [15:0] rtgt;
      logic        rpt;
      logic [15:0] rptgt;
      logic        e_pt;
      logic [15:0] e_tgt;
      logic        e_mp;
      logic [15:0] e_rd;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic [15:0] ipc, input logic ibr, input logic rv,
                               input logic [15:0] rpc, input logic rt, input logic [15:0] rtgt,
                               input logic rpt, input logic [15:0] rptgt, input logic e_pt,
                               input logic [15:0] e_tgt, input logic e_mp, input logic [15:0] e_rd);
      vec_t v;
      v.if_pc = ipc;  v.if_br = ibr;  v.rv = rv;     v.rpc = rpc;
      v.rt = rt;      v.rtgt = rtgt;  v.rpt = rpt;   v.rptgt = rptgt;
      v.e_pt = e_pt;  v.e_tgt = e_tgt; v.e_mp = e_mp; v.e_rd = e_rd;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      if_pc = 16'h0000; if_is_branch = 1'b0;
      res_valid = 1'b0; res_pc = 16'h0000; res_taken = 1'b0;
      res_target = 16'h0000; res_pred_taken = 1'b0; res_pred_target = 16'h0000;
   endtask

   task automatic drive_vec(input vec_t v);
      if_pc = v.if_pc; if_is_branch = v.if_br;
      res_valid = v.rv; res_pc = v.rpc; res_taken = v.rt;
      res_target = v.rtgt; res_pred_taken = v.rpt; res_pred_target = v.rptgt;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      // Scenario walked through one cycle per row; table state carries between rows.
      vecs[0]  = mk(16'h3000,1, 0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0000, 0,16'h0002);
      vecs[1]  = mk(16'h3000,1, 1,16'h3000,1,16'h3040,0,16'h0000, 0,16'h0000, 1,16'h3040);
      vecs[2]  = mk(16'h3000,1, 0,16'h0000,0,16'h0000,0,16'h0000, 1,16'h3040, 0,16'h0002);
      for (int i = 3; i < 8; i++)
         vecs[i] = mk(16'h3000,0, 1,16'h3000,1,16'h3040,1,16'h3040, 0,16'h0000, 0,16'h3040);
      vecs[8]  = mk(16'h3000,1, 1,16'h3000,0,16'h0000,1,16'h3040, 1,16'h3040, 1,16'h3002);
      vecs[9]  = mk(16'h3000,1, 1,16'h3000,0,16'h0000,1,16'h3040, 1,16'h3040, 1,16'h3002);
      vecs[10] = mk(16'h3000,1, 0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0000, 0,16'h0002);
      vecs[11] = mk(16'h3000,1, 1,16'h3000,1,16'h3080,1,16'h3040, 0,16'h0000, 1,16'h3080);
      vecs[12] = mk(16'h3000,1, 0,16'h0000,0,16'h0000,0,16'h0000, 1,16'h3080, 0,16'h0002);
      vecs[13] = mk(16'h3000,1, 1,16'h3020,1,16'h3100,0,16'h0000, 1,16'h3080, 1,16'h3100);
      vecs[14] = mk(16'h3000,1, 0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0000, 0,16'h0002);
      vecs[15] = mk(16'h3020,1, 0,16'h0000,0,16'h0000,0,16'h0000, 1,16'h3100, 0,16'h0002);
      vecs[16] = mk(16'h3442,1, 1,16'h3442,0,16'h0000,0,16'h0000, 0,16'h0000, 0,16'h3444);
      vecs[17] = mk(16'h3442,1, 0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0000, 0,16'h0002);
      vecs[18] = mk(16'h3020,1, 1,16'hFFFE,0,16'h0000,1,16'h1234, 1,16'h3100, 1,16'h0000);

      do_reset();
      if_pc = 16'h3000; if_is_branch = 1'b1;
      #1;
      check("reset_pred_taken", {15'd0, pred_taken}, 16'h0000);
      check("reset_pred_target", pred_target, 16'h0000);
      check("reset_stat_hits", stat_hits, 16'h0000);
      check("reset_stat_mispredicts", stat_mispredicts, 16'h0000);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive_vec(vecs[i]);
         #1;
         check($sformatf("v%0d_pred_taken", i), {15'd0, pred_taken}, {15'd0, vecs[i].e_pt});
         check($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_tgt);
         check($sformatf("v%0d_mispredict", i), {15'd0, mispredict}, {15'd0, vecs[i].e_mp});
         check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rd);
      end

      // Hits: rows 2,8,9,12,13,15,18. Mispredicts: rows 1,8,9,11,13,18.
      @(negedge clk);
      drive_idle();
      #1;
      check("stat_hits_total", stat_hits, 16'd7);
      check("stat_mispredicts_total", stat_mispredicts, 16'd6);

      // Reset coincident with a training write and a live hit on index 0.
      @(negedge clk);
      rst_n = 1'b0;
      if_pc = 16'h3020; if_is_branch = 1'b1;
      res_valid = 1'b1; res_pc = 16'h3040; res_taken = 1'b1;
      res_target = 16'h3200; res_pred_taken = 1'b0; res_pred_target = 16'h0000;
      #1;
      check("in_reset_pred_taken", {15'd0, pred_taken}, 16'h0000);
      check("in_reset_pred_target", pred_target, 16'h0000);
      check("in_reset_mispredict", {15'd0, mispredict}, 16'h0001);
      check("in_reset_redirect_pc", redirect_pc, 16'h3200);
      @(negedge clk);
      rst_n = 1'b1;
      drive_idle();
      if_pc = 16'h3020; if_is_branch = 1'b1;
      #1;
      check("post_reset_old_entry", {15'd0, pred_taken}, 16'h0000);
      check("post_reset_stat_hits", stat_hits, 16'h0000);
      check("post_reset_stat_mispredicts", stat_mispredicts, 16'h0000);
      @(negedge clk);
      if_pc = 16'h3040;
      #1;
      check("post_reset_blocked_write", {15'd0, pred_taken}, 16'h0000);
      check("post_reset_blocked_target", pred_target, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
